cc_data_reorder_unit: RTL and testbench
=======================================

// Module: cc_data_reorder_unit
// PURPOSE
//  Cache-controller read-return path. Merges hit data (local 512b lines) and miss data (64b DRAM beats) back into request order.
//  Order comes from a hit-flag FIFO. Output is an 8-beat, 64b burst stream to the interconnect.
// PARAMETERS
//  FLAG_FIFO_DEPTH  16  entries in hit-flag FIFO (power of 2)
//  DATA_FIFO_DEPTH  4   entries in hit-data FIFO (power of 2)
// PORTS
//  clk                    in   1    clock, all logic on posedge
//  rst_n                  in   1    asynchronous active-low reset
//  mem_rdata_i            in   64   DRAM read beat
//  mem_rlast_i            in   1    last beat of DRAM burst
//  mem_rvalid_i           in   1    DRAM beat valid
//  mem_rready_o           out  1    DRAM beat accepted
//  hit_flag_fifo_afull_o  out  1    flag FIFO occupancy >= FLAG_FIFO_DEPTH-1
//  hit_flag_fifo_wren_i   in   1    push request-order flag
//  hit_flag_fifo_wdata_i  in   1    1=hit (data from hit FIFO), 0=miss (data from DRAM)
//  hit_data_fifo_afull_o  out  1    data FIFO occupancy >= DATA_FIFO_DEPTH-1
//  hit_data_fifo_wren_i   in   1    push hit line
//  hit_data_fifo_wdata_i  in   518  [517:512]=request byte offset, [511:0]=line (word k = [64k+63:64k])
//  inct_rdata_o           out  64   return beat
//  inct_rlast_o           out  1    last (8th) beat of burst
//  inct_rvalid_o          out  1    return beat valid
//  inct_rready_i          in   1    interconnect accepts beat
// BEHAVIOUR
//  - Both FIFOs synchronous, first-word-fall-through. Push to a full FIFO is dropped; afull lets producers stop early.
//  - Simultaneous push+pop is legal at any occupancy, including full.
//  - Reset: FIFOs empty, beat counter=0, afull=0, inct_rvalid_o=0, inct_rlast_o=0, inct_rdata_o=0, mem_rready_o=0.
//  - Head flag selects source. No flag entry -> inct_rvalid_o=0, mem_rready_o=0 (DRAM back-pressured).
//  - MISS (head flag=0): combinational pass-through, zero latency.
//    inct_rdata_o=mem_rdata_i, inct_rvalid_o=mem_rvalid_i, inct_rlast_o=mem_rlast_i, mem_rready_o=inct_rready_i.
//    Pop flag on the handshake where mem_rlast_i=1.
//  - HIT (head flag=1): mem_rready_o=0.
//    Hit-data FIFO empty -> inct_rvalid_o=0 (wait).
//    Non-empty -> inct_rvalid_o=1; beat n (n=0..7, 3b counter) sends word (start+n) mod 8; inct_rlast_o=1 when n==7.
//    Counter advances only on valid&ready. On beat 7 handshake: counter->0, pop flag and data FIFOs together.
//  - Outputs hold stable while valid&!ready (AXI-style); the next burst may start the cycle after rlast.
//  - afull flags are registered from occupancy and update the cycle after a push/pop.
//  - rst_n assertion mid-burst aborts the burst; the FIFOs and counter clear immediately (async).
// CONFIGURATION
//  CC_REORDER_CRITICAL_WORD_FIRST_EN defined: hit start word = wdata[517:515] (offset[5:3]), wrap burst.
//  Not defined: hit start word = 0 always, offset bits ignored. Miss path unaffected either way.
// TESTING
//  1 Reset: rst_n=0 -> all outputs 0, afull 0. Release; no pushes -> inct_rvalid_o stays 0, mem_rready_o 0.
//  2 Hit, offset 0: push flag=1, line word k=64'h1000+k, ready=1.
//    -> 8 beats 1000..1007 on consecutive cycles, rlast on 1007, FIFOs empty after.
//  3 Hit CWF: offset 6'h28 with macro.
//    -> beats 1005,1006,1007,1000..1004. Without macro -> 1000..1007.
//  4 Miss then hit: push flags 0,1; hit line queued first; DRAM beats A0..A7 (rlast on A7).
//    -> output A0..A7, then hit burst. Hit data not emitted before A7.
//  5 Backpressure: ready toggles 1/0 during hit burst -> each beat held while ready=0, no beat lost or repeated.
//    Miss path: mem_rready_o mirrors ready.
//  6 FIFO limits: push 15 flags with no pops -> afull=1. 17th push dropped; occupancy stays 16.
//    Push+pop when full -> occupancy unchanged.

Source files
------------

// File: rtl/cc_data_reorder_unit.sv
// Read-return reorder unit: merges local hit lines and DRAM miss beats back into request order.
// Optional feature: define CC_REORDER_CRITICAL_WORD_FIRST_EN to start hit bursts at the requested word.
module cc_data_reorder_unit #(
  parameter int FLAG_FIFO_DEPTH = 16,
  parameter int DATA_FIFO_DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [63:0]  mem_rdata_i,
  input  logic         mem_rlast_i,
  input  logic         mem_rvalid_i,
  output logic         mem_rready_o,
  output logic         hit_flag_fifo_afull_o,
  input  logic         hit_flag_fifo_wren_i,
  input  logic         hit_flag_fifo_wdata_i,
  output logic         hit_data_fifo_afull_o,
  input  logic         hit_data_fifo_wren_i,
  input  logic [517:0] hit_data_fifo_wdata_i,
  output logic [63:0]  inct_rdata_o,
  output logic         inct_rlast_o,
  output logic         inct_rvalid_o,
  input  logic         inct_rready_i
);

  localparam int FW = $clog2(FLAG_FIFO_DEPTH);
  localparam int DW = $clog2(DATA_FIFO_DEPTH);

  localparam logic [FW-1:0] FLAG_PTR_ONE = 1;
  localparam logic [FW:0]   FLAG_CNT_ONE = 1;
  localparam logic [FW:0]   FLAG_FULL_C  = (FW+1)'(FLAG_FIFO_DEPTH);
  localparam logic [FW:0]   FLAG_AFULL_C = (FW+1)'(FLAG_FIFO_DEPTH - 1);

  localparam logic [DW-1:0] DATA_PTR_ONE = 1;
  localparam logic [DW:0]   DATA_CNT_ONE = 1;
  localparam logic [DW:0]   DATA_FULL_C  = (DW+1)'(DATA_FIFO_DEPTH);
  localparam logic [DW:0]   DATA_AFULL_C = (DW+1)'(DATA_FIFO_DEPTH - 1);

  // ---------------------------------------------------------------------------
  // Hit-flag FIFO (first-word-fall-through)
  // ---------------------------------------------------------------------------
  logic          flag_mem [FLAG_FIFO_DEPTH];
  logic [FW-1:0] flag_wptr, flag_rptr;
  logic [FW:0]   flag_count, flag_count_nxt;
  logic          flag_push, flag_pop, flag_head, flag_empty;

  assign flag_empty = (flag_count == '0);
  assign flag_head  = flag_mem[flag_rptr];
  // A pop in the same cycle frees the slot, so a push at full is still accepted.
  assign flag_push  = hit_flag_fifo_wren_i && ((flag_count != FLAG_FULL_C) || flag_pop);

  always_comb begin
    flag_count_nxt = flag_count;
    if (flag_push && !flag_pop)      flag_count_nxt = flag_count + FLAG_CNT_ONE;
    else if (!flag_push && flag_pop) flag_count_nxt = flag_count - FLAG_CNT_ONE;
  end

  // NOTE: storage arrays carry no reset; pointers and counts define which entries are live.
  always_ff @(posedge clk) begin
    if (flag_push) flag_mem[flag_wptr] <= hit_flag_fifo_wdata_i;
  end

  // NOTE: sequential state uses non-blocking '<=' so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flag_wptr             <= '0;
      flag_rptr             <= '0;
      flag_count            <= '0;
      hit_flag_fifo_afull_o <= 1'b0;
    end else begin
      if (flag_push) flag_wptr <= flag_wptr + FLAG_PTR_ONE;
      if (flag_pop)  flag_rptr <= flag_rptr + FLAG_PTR_ONE;
      flag_count            <= flag_count_nxt;
      hit_flag_fifo_afull_o <= (flag_count_nxt >= FLAG_AFULL_C);
    end
  end

  // ---------------------------------------------------------------------------
  // Hit-data FIFO (first-word-fall-through)
  // ---------------------------------------------------------------------------
  logic [517:0]  data_mem [DATA_FIFO_DEPTH];
  logic [DW-1:0] data_wptr, data_rptr;
  logic [DW:0]   data_count, data_count_nxt;
  logic          data_push, data_pop, data_empty;
  logic [517:0]  data_head;

  assign data_empty = (data_count == '0);
  assign data_head  = data_mem[data_rptr];
  assign data_push  = hit_data_fifo_wren_i && ((data_count != DATA_FULL_C) || data_pop);

  always_comb begin
    data_count_nxt = data_count;
    if (data_push && !data_pop)      data_count_nxt = data_count + DATA_CNT_ONE;
    else if (!data_push && data_pop) data_count_nxt = data_count - DATA_CNT_ONE;
  end

  always_ff @(posedge clk) begin
    if (data_push) data_mem[data_wptr] <= hit_data_fifo_wdata_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_wptr             <= '0;
      data_rptr             <= '0;
      data_count            <= '0;
      hit_data_fifo_afull_o <= 1'b0;
    end else begin
      if (data_push) data_wptr <= data_wptr + DATA_PTR_ONE;
      if (data_pop)  data_rptr <= data_rptr + DATA_PTR_ONE;
      data_count            <= data_count_nxt;
      hit_data_fifo_afull_o <= (data_count_nxt >= DATA_AFULL_C);
    end
  end

  // ---------------------------------------------------------------------------
  // Hit burst sequencing
  // ---------------------------------------------------------------------------
  logic [2:0]  beat_cnt;
  logic [2:0]  start_word;
  logic [2:0]  word_idx;
  logic        beat_adv;
  logic [63:0] head_words [8];

`ifdef CC_REORDER_CRITICAL_WORD_FIRST_EN
  assign start_word = data_head[517:515];
  logic unused_offset;
  assign unused_offset = ^data_head[514:512];
`else
  assign start_word = 3'd0;
  logic unused_offset;
  assign unused_offset = ^data_head[517:512];
`endif

  // 3-bit add wraps the burst around the line.
  assign word_idx = start_word + beat_cnt;

  always_comb begin
    for (int k = 0; k < 8; k++) head_words[k] = data_head[64*k +: 64];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        beat_cnt <= 3'd0;
    else if (beat_adv) beat_cnt <= beat_cnt + 3'd1;
  end

  // ---------------------------------------------------------------------------
  // Source select: head flag steers the return stream
  // ---------------------------------------------------------------------------
  // NOTE: always_comb uses blocking '=' and gives every output a default first, so no latch is inferred.
  always_comb begin
    inct_rdata_o  = 64'd0;
    inct_rvalid_o = 1'b0;
    inct_rlast_o  = 1'b0;
    mem_rready_o  = 1'b0;
    flag_pop      = 1'b0;
    data_pop      = 1'b0;
    beat_adv      = 1'b0;
    if (!flag_empty) begin
      if (!flag_head) begin
        inct_rdata_o  = mem_rdata_i;
        inct_rvalid_o = mem_rvalid_i;
        inct_rlast_o  = mem_rlast_i;
        mem_rready_o  = inct_rready_i;
        flag_pop      = mem_rvalid_i && inct_rready_i && mem_rlast_i;
      end else if (!data_empty) begin
        inct_rdata_o  = head_words[word_idx];
        inct_rvalid_o = 1'b1;
        inct_rlast_o  = (beat_cnt == 3'd7);
        if (inct_rready_i) begin
          beat_adv = 1'b1;
          if (beat_cnt == 3'd7) begin
            flag_pop = 1'b1;
            data_pop = 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_cc_data_reorder_unit.sv
// Directed self-checking bench for cc_data_reorder_unit: reset, hit/miss ordering, CWF, backpressure, FIFO limits.
module tb_cc_data_reorder_unit;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [63:0]  mem_rdata;
  logic         mem_rlast, mem_rvalid, mem_rready;
  logic         flag_afull, flag_wren, flag_wdata;
  logic         data_afull, data_wren;
  logic [517:0] data_wdata;
  logic [63:0]  inct_rdata;
  logic         inct_rlast, inct_rvalid, inct_rready;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  cc_data_reorder_unit dut (
    .clk                   (clk),
    .rst_n                 (rst_n),
    .mem_rdata_i           (mem_rdata),
    .mem_rlast_i           (mem_rlast),
    .mem_rvalid_i          (mem_rvalid),
    .mem_rready_o          (mem_rready),
    .hit_flag_fifo_afull_o (flag_afull),
    .hit_flag_fifo_wren_i  (flag_wren),
    .hit_flag_fifo_wdata_i (flag_wdata),
    .hit_data_fifo_afull_o (data_afull),
    .hit_data_fifo_wren_i  (data_wren),
    .hit_data_fifo_wdata_i (data_wdata),
    .inct_rdata_o          (inct_rdata),
    .inct_rlast_o          (inct_rlast),
    .inct_rvalid_o         (inct_rvalid),
    .inct_rready_i         (inct_rready)
  );

  // Inputs change 1 time unit after the rising edge; outputs are sampled 1 unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [517:0] make_line(input logic [5:0] off, input logic [63:0] base);
    logic [517:0] l;
    for (int k = 0; k < 8; k++) l[64*k +: 64] = base + 64'(k);
    l[517:512] = off;
    return l;
  endfunction

  function automatic int exp_start(input logic [5:0] off);
`ifdef CC_REORDER_CRITICAL_WORD_FIRST_EN
    return int'(off[5:3]);
`else
    return 0;
`endif
  endfunction

  task automatic test_reset();
    rst_n = 1'b0; mem_rdata = 64'h55; mem_rlast = 1'b0; mem_rvalid = 1'b1; inct_rready = 1'b1;
    flag_wren = 1'b0; flag_wdata = 1'b0; data_wren = 1'b0; data_wdata = '0;
    #3;
    total++; if (inct_rvalid !== 1'b0) $display("FAIL reset_rvalid: got %b want 0", inct_rvalid); else passed++;
    total++; if (inct_rlast !== 1'b0) $display("FAIL reset_rlast: got %b want 0", inct_rlast); else passed++;
    total++; if (inct_rdata !== 64'd0) $display("FAIL reset_rdata: got %h want 0", inct_rdata); else passed++;
    total++; if (mem_rready !== 1'b0) $display("FAIL reset_mem_rready: got %b want 0", mem_rready); else passed++;
    total++; if (flag_afull !== 1'b0) $display("FAIL reset_flag_afull: got %b want 0", flag_afull); else passed++;
    total++; if (data_afull !== 1'b0) $display("FAIL reset_data_afull: got %b want 0", data_afull); else passed++;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #1;
      total++; if (inct_rvalid !== 1'b0) $display("FAIL idle_rvalid c=%0d: got %b want 0", c, inct_rvalid); else passed++;
      total++; if (mem_rready !== 1'b0) $display("FAIL idle_mem_rready c=%0d: got %b want 0", c, mem_rready); else passed++;
      tick();
    end
    mem_rvalid = 1'b0;
  endtask

  // Push one hit flag together with its line, then expect an uninterrupted 8-beat burst.
  task automatic run_hit(input string name, input logic [5:0] off, input logic [63:0] base);
    int s;
    s = exp_start(off);
    inct_rready = 1'b1;
    flag_wren = 1'b1; flag_wdata = 1'b1; data_wren = 1'b1; data_wdata = make_line(off, base);
    tick();
    flag_wren = 1'b0; data_wren = 1'b0;
    for (int n = 0; n < 8; n++) begin
      #1;
      total++; if (inct_rvalid !== 1'b1) $display("FAIL %s_valid n=%0d: got %b want 1", name, n, inct_rvalid); else passed++;
      total++; if (inct_rdata !== base + 64'((s + n) % 8))
        $display("FAIL %s_data n=%0d: got %h want %h", name, n, inct_rdata, base + 64'((s + n) % 8)); else passed++;
      total++; if (inct_rlast !== (n == 7)) $display("FAIL %s_last n=%0d: got %b want %b", name, n, inct_rlast, n == 7); else passed++;
      tick();
    end
    #1;
    total++; if (inct_rvalid !== 1'b0) $display("FAIL %s_after_valid: got %b want 0", name, inct_rvalid); else passed++;
    total++; if (mem_rready !== 1'b0) $display("FAIL %s_after_mem_rready: got %b want 0", name, mem_rready); else passed++;
    total++; if (flag_afull !== 1'b0 || data_afull !== 1'b0)
      $display("FAIL %s_after_afull: got %b%b want 00", name, flag_afull, data_afull); else passed++;
    tick();
  endtask

  task automatic test_hit_offset0();
    run_hit("hit0", 6'h00, 64'h1000);
  endtask

  task automatic test_hit_cwf();
    run_hit("cwf", 6'h28, 64'h1000);
  endtask

  task automatic test_miss_then_hit();
    inct_rready = 1'b1;
    flag_wren = 1'b1; flag_wdata = 1'b0; data_wren = 1'b1; data_wdata = make_line(6'h00, 64'h3000);
    tick();
    flag_wdata = 1'b1; data_wren = 1'b0;
    tick();
    flag_wren = 1'b0;
    #1;
    total++; if (inct_rvalid !== 1'b0) $display("FAIL mh_wait_valid: got %b want 0", inct_rvalid); else passed++;
    total++; if (mem_rready !== 1'b1) $display("FAIL mh_wait_mem_rready: got %b want 1", mem_rready); else passed++;
    tick();
    for (int i = 0; i < 8; i++) begin
      mem_rvalid = 1'b1; mem_rdata = 64'hA0 + 64'(i); mem_rlast = (i == 7);
      #1;
      total++; if (inct_rdata !== 64'hA0 + 64'(i)) $display("FAIL mh_miss_data i=%0d: got %h want %h", i, inct_rdata, 64'hA0 + 64'(i)); else passed++;
      total++; if (inct_rvalid !== 1'b1 || inct_rlast !== (i == 7))
        $display("FAIL mh_miss_ctrl i=%0d: got v=%b l=%b want v=1 l=%b", i, inct_rvalid, inct_rlast, i == 7); else passed++;
      total++; if (mem_rready !== 1'b1) $display("FAIL mh_miss_rready i=%0d: got %b want 1", i, mem_rready); else passed++;
      tick();
    end
    mem_rvalid = 1'b0; mem_rlast = 1'b0;
    for (int n = 0; n < 8; n++) begin
      #1;
      total++; if (inct_rvalid !== 1'b1 || inct_rdata !== 64'h3000 + 64'(n) || inct_rlast !== (n == 7))
        $display("FAIL mh_hit n=%0d: got v=%b d=%h l=%b want v=1 d=%h l=%b", n, inct_rvalid, inct_rdata, inct_rlast,
                 64'h3000 + 64'(n), n == 7); else passed++;
      tick();
    end
    #1;
    total++; if (inct_rvalid !== 1'b0) $display("FAIL mh_after_valid: got %b want 0", inct_rvalid); else passed++;
    tick();
  endtask

  task automatic test_backpressure();
    int n;
    n = 0;
    flag_wren = 1'b1; flag_wdata = 1'b1; data_wren = 1'b1; data_wdata = make_line(6'h00, 64'h2000);
    inct_rready = 1'b0;
    tick();
    flag_wren = 1'b0; data_wren = 1'b0;
    for (int c = 0; c < 40 && n < 8; c++) begin
      inct_rready = c[0];
      #1;
      total++; if (inct_rvalid !== 1'b1 || inct_rdata !== 64'h2000 + 64'(n) || inct_rlast !== (n == 7))
        $display("FAIL bp_beat c=%0d n=%0d: got v=%b d=%h l=%b want v=1 d=%h l=%b", c, n, inct_rvalid, inct_rdata,
                 inct_rlast, 64'h2000 + 64'(n), n == 7); else passed++;
      tick();
      if (inct_rready) n++;
    end
    total++; if (n != 8) $display("FAIL bp_beats_done: got %0d want 8", n); else passed++;
    inct_rready = 1'b1;
    #1;
    total++; if (inct_rvalid !== 1'b0) $display("FAIL bp_after_valid: got %b want 0", inct_rvalid); else passed++;
    tick();
    flag_wren = 1'b1; flag_wdata = 1'b0;
    tick();
    flag_wren = 1'b0;
    mem_rvalid = 1'b1; mem_rdata = 64'hB0; mem_rlast = 1'b1; inct_rready = 1'b0;
    #1;
    total++; if (mem_rready !== 1'b0) $display("FAIL bp_miss_rready0: got %b want 0", mem_rready); else passed++;
    total++; if (inct_rvalid !== 1'b1 || inct_rdata !== 64'hB0)
      $display("FAIL bp_miss_hold: got v=%b d=%h want v=1 d=b0", inct_rvalid, inct_rdata); else passed++;
    tick();
    inct_rready = 1'b1;
    #1;
    total++; if (mem_rready !== 1'b1) $display("FAIL bp_miss_rready1: got %b want 1", mem_rready); else passed++;
    tick();
    mem_rvalid = 1'b0; mem_rlast = 1'b0;
    #1;
    total++; if (mem_rready !== 1'b0) $display("FAIL bp_miss_popped: got %b want 0", mem_rready); else passed++;
    tick();
  endtask

  task automatic test_fifo_limits();
    int  cnt;
    bit  done;
    inct_rready = 1'b1; mem_rvalid = 1'b0;
    // 16 misses fill the FIFO; the 17th (a hit) must be dropped.
    for (int i = 0; i < 17; i++) begin
      flag_wren = 1'b1; flag_wdata = (i == 16);
      tick();
      if (i == 13) begin
        total++; if (flag_afull !== 1'b0) $display("FAIL lim_afull_14: got %b want 0", flag_afull); else passed++;
      end
      if (i == 14) begin
        total++; if (flag_afull !== 1'b1) $display("FAIL lim_afull_15: got %b want 1", flag_afull); else passed++;
      end
    end
    flag_wdata = 1'b0;
    mem_rvalid = 1'b1; mem_rlast = 1'b1; mem_rdata = 64'hC0;
    #1;
    total++; if (mem_rready !== 1'b1) $display("FAIL lim_pushpop_rready: got %b want 1", mem_rready); else passed++;
    tick();
    flag_wren = 1'b0;
    #1;
    total++; if (flag_afull !== 1'b1) $display("FAIL lim_pushpop_afull: got %b want 1", flag_afull); else passed++;
    cnt = 0; done = 0;
    for (int c = 0; c < 40 && !done; c++) begin
      if (c != 0) #1;
      if (mem_rready) begin
        cnt++;
        tick();
      end else done = 1;
    end
    total++; if (cnt != 16) $display("FAIL lim_occupancy: got %0d want 16", cnt); else passed++;
    mem_rvalid = 1'b0; mem_rlast = 1'b0;
    total++; if (flag_afull !== 1'b0) $display("FAIL lim_drained_afull: got %b want 0", flag_afull); else passed++;
    tick();
  endtask

  task automatic test_data_afull_and_abort();
    inct_rready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      data_wren = 1'b1; data_wdata = make_line(6'h00, 64'h4000 + 64'(16 * i));
      tick();
      if (i == 1) begin
        total++; if (data_afull !== 1'b0) $display("FAIL dafull_2: got %b want 0", data_afull); else passed++;
      end
    end
    data_wren = 1'b0;
    total++; if (data_afull !== 1'b1) $display("FAIL dafull_3: got %b want 1", data_afull); else passed++;
    flag_wren = 1'b1; flag_wdata = 1'b1; inct_rready = 1'b1;
    tick();
    flag_wren = 1'b0;
    #1;
    total++; if (inct_rdata !== 64'h4000) $display("FAIL abort_first: got %h want 4000", inct_rdata); else passed++;
    repeat (3) tick();
    #1;
    total++; if (inct_rdata !== 64'h4003) $display("FAIL abort_mid: got %h want 4003", inct_rdata); else passed++;
    rst_n = 1'b0;
    #1;
    total++; if (inct_rvalid !== 1'b0 || inct_rdata !== 64'd0 || data_afull !== 1'b0)
      $display("FAIL abort_cleared: got v=%b d=%h af=%b want 0 0 0", inct_rvalid, inct_rdata, data_afull); else passed++;
    tick();
    rst_n = 1'b1;
    tick();
    run_hit("post_abort", 6'h00, 64'h5000);
  endtask

  initial begin
    test_reset();
    test_hit_offset0();
    test_hit_cwf();
    test_miss_then_hit();
    test_backpressure();
    test_fifo_limits();
    test_data_afull_and_abort();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
